// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: access sizes, FSM states
// and the alignment rule used when misalignment checking is built in.
package lsu_pkg;

  localparam int WORD_BYTES = 4;
  localparam int OFFS_W     = $clog2(WORD_BYTES);

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } lsu_size_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD     = 3'd1,
    RMW_RD = 3'd2,
    WR     = 3'd3,
    RSP    = 3'd4
  } lsu_state_t;

  // Encoding 3 on the request bus behaves as a full word.
  function automatic lsu_size_t to_size(input logic [1:0] raw);
    case (raw)
      2'd0:    return SZ_BYTE;
      2'd1:    return SZ_HALF;
      default: return SZ_WORD;
    endcase
  endfunction

  function automatic logic is_misaligned(input lsu_size_t size, input logic [OFFS_W-1:0] offset);
    case (size)
      SZ_HALF: return offset[0];
      SZ_WORD: return offset != '0;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_mem_master_if.sv
// Request, response and word-memory signals of the load/store unit.
// master = the LSU itself, slave = processor/memory side.
interface lsu_mem_master_if #(
  parameter int ADDR_WIDTH = 32
);

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_wdata;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [31:0]           rsp_rdata;
  logic                  rsp_error;

  logic [ADDR_WIDTH-1:0] mem_address;
  logic [31:0]           mem_writeData;
  logic                  mem_memWrite;
  logic                  mem_memRead;
  logic [31:0]           mem_readData;

  modport master (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  rsp_ready, mem_readData,
    output req_ready, rsp_valid, rsp_rdata, rsp_error,
    output mem_address, mem_writeData, mem_memWrite, mem_memRead
  );

  modport slave (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output rsp_ready, mem_readData,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error,
    input  mem_address, mem_writeData, mem_memWrite, mem_memRead
  );

endinterface

// File: rtl/lsu_lane_align.sv
// Little-endian byte-lane steering: extracts and extends a load lane from a
// memory word, and merges store data into a word for read-modify-write.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [1:0]  offset,
  input  lsu_size_t   size,
  input  logic        is_unsigned,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Halfwords only look at offset[1]; offset[0] is either rejected upstream or ignored.
  always_comb begin
    byte_lane  = word[{offset, 3'b000} +: 8];
    half_lane  = offset[1] ? word[31:16] : word[15:0];
    load_data  = word;
    store_word = wdata;
    case (size)
      SZ_BYTE: begin
        load_data  = {{24{~is_unsigned & byte_lane[7]}}, byte_lane};
        store_word = word;
        store_word[{offset, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_HALF: begin
        load_data  = {{16{~is_unsigned & half_lane[15]}}, half_lane};
        store_word = offset[1] ? {wdata[15:0], word[15:0]} : {word[31:16], wdata[15:0]};
      end
      default: begin
        load_data  = word;
        store_word = wdata;
      end
    endcase
  end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store unit between the MEM stage and a word-wide data memory.
// Build option: define LSU_MISALIGN_CHECK_EN to reject misaligned half/word accesses.
//
// state  | meaning
// IDLE   | req_ready high, waiting for a request
// RD     | memory read for a load; lane captured into rsp_rdata
// RMW_RD | memory read for a byte/half store; lane merged into write word
// WR     | single-cycle memory write of full or merged word
// RSP    | response held until rsp_ready
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter bit STORE_RSP_DATA = 1'b0
) (
  input logic              clock,
  input logic              reset_n,
  lsu_mem_master_if.master bus
);

  lsu_state_t       state_q;
  logic [1:0]       addr_lo_q;
  lsu_size_t        size_q;
  logic             unsigned_q;
  logic [31:0]      wdata_q;
  logic             rsp_error_q;
  logic             misalign;
  logic [31:0]      load_data;
  logic [31:0]      store_word;
  lsu_size_t        req_size_n;

  assign req_size_n    = to_size(bus.req_size);
  assign bus.rsp_error = rsp_error_q;

`ifdef LSU_MISALIGN_CHECK_EN
  assign misalign = is_misaligned(req_size_n, bus.req_addr[OFFS_W-1:0]);
`else
  assign misalign = 1'b0;
`endif

  lsu_lane_align u_align (
    .word        (bus.mem_readData),
    .wdata       (wdata_q),
    .offset      (addr_lo_q),
    .size        (size_q),
    .is_unsigned (unsigned_q),
    .load_data   (load_data),
    .store_word  (store_word)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q           <= IDLE;
      addr_lo_q         <= 2'b00;
      size_q            <= SZ_BYTE;
      unsigned_q        <= 1'b0;
      wdata_q           <= '0;
      rsp_error_q       <= 1'b0;
      bus.req_ready     <= 1'b1;
      bus.rsp_valid     <= 1'b0;
      bus.rsp_rdata     <= '0;
      bus.mem_address   <= '0;
      bus.mem_writeData <= '0;
      bus.mem_memWrite  <= 1'b0;
      bus.mem_memRead   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            addr_lo_q       <= bus.req_addr[1:0];
            size_q          <= req_size_n;
            unsigned_q      <= bus.req_unsigned;
            wdata_q         <= bus.req_wdata;
            rsp_error_q     <= misalign;
            bus.req_ready   <= 1'b0;
            bus.mem_address <= {bus.req_addr[ADDR_WIDTH-1:OFFS_W], {OFFS_W{1'b0}}};
            if (misalign) begin
              bus.rsp_rdata <= '0;
              bus.rsp_valid <= 1'b1;
              state_q       <= RSP;
            end else if (!bus.req_write) begin
              bus.mem_memRead <= 1'b1;
              state_q         <= RD;
            end else if (req_size_n == SZ_WORD) begin
              bus.mem_writeData <= bus.req_wdata;
              bus.mem_memWrite  <= 1'b1;
              state_q           <= WR;
            end else begin
              bus.mem_memRead <= 1'b1;
              state_q         <= RMW_RD;
            end
          end
        end
        RD: begin
          bus.rsp_rdata   <= load_data;
          bus.mem_memRead <= 1'b0;
          bus.rsp_valid   <= 1'b1;
          state_q         <= RSP;
        end
        RMW_RD: begin
          bus.mem_writeData <= store_word;
          bus.mem_memRead   <= 1'b0;
          bus.mem_memWrite  <= 1'b1;
          state_q           <= WR;
        end
        WR: begin
          bus.mem_memWrite <= 1'b0;
          bus.rsp_rdata    <= STORE_RSP_DATA ? bus.mem_writeData : 32'h0;
          bus.rsp_valid    <= 1'b1;
          state_q          <= RSP;
        end
        RSP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            bus.req_ready <= 1'b1;
            state_q       <= IDLE;
          end
        end
        default: begin
          bus.mem_memRead  <= 1'b0;
          bus.mem_memWrite <= 1'b0;
          bus.rsp_valid    <= 1'b0;
          bus.req_ready    <= 1'b1;
          state_q          <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench for lsu_mem_master with a byte-array reference memory and a
// per-cycle output checker. Honours LSU_MISALIGN_CHECK_EN when defined.
module tb_lsu_mem_master;

  localparam int AW             = 32;
  localparam bit STORE_RSP_DATA = 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          nrd;
    int          nwr;
    logic [31:0] wr_word;
    logic [31:0] waddr;
    int          lat;
    int          acc_cyc;
  } exp_t;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  lsu_mem_master_if #(.ADDR_WIDTH(AW)) bus ();

  lsu_mem_master #(
    .ADDR_WIDTH     (AW),
    .STORE_RSP_DATA (STORE_RSP_DATA)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.master)
  );

  // Word memory attached to the DUT
  logic [31:0] mem_arr [64] = '{default: 32'h0};
  always @(posedge clock) if (bus.mem_memWrite) mem_arr[bus.mem_address[7:2]] <= bus.mem_writeData;
  assign bus.mem_readData = bus.mem_memRead ? mem_arr[bus.mem_address[7:2]] : 32'h0;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  bit          chk_en = 1'b0;
  logic [7:0]  ref_bytes [256];
  exp_t        exp_q [$];
  bit          prev_hs, prev_cont;
  int          rd_seen, wr_seen;
  logic [31:0] last_wr, got;
  logic        got_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=event (t=%0t)", name, $time);
  endtask

  // Reference behaviour from byte-addressed memory semantics.
  task automatic predict(input bit w, input logic [1:0] sz, input bit u,
                         input logic [31:0] a, input logic [31:0] wd, output exp_t e);
    int eff, nb, base, wbase;
    logic [31:0] val, ones;
    bit mis;
    eff  = (sz == 2'd3) ? 2 : int'(sz);
    nb   = 1 << eff;
    e.waddr   = {a[31:2], 2'b00};
    e.wr_word = 32'h0;
    e.err     = 1'b0;
    e.acc_cyc = 0;
    mis = MIS_EN && ((eff == 1 && a[0]) || (eff == 2 && a[1:0] != 2'b00));
    if (mis) begin
      e.rdata = 32'h0; e.err = 1'b1; e.nrd = 0; e.nwr = 0; e.lat = 0;
    end else begin
      base  = int'(a[7:0]) & ~(nb - 1);
      wbase = int'(a[7:0]) & ~3;
      if (!w) begin
        val = 32'h0;
        for (int i = 0; i < nb; i++) val |= 32'(ref_bytes[base + i]) << (8 * i);
        if (!u && nb < 4 && val[8 * nb - 1]) begin
          ones = '1;
          val |= ones << (8 * nb);
        end
        e.rdata = val; e.nrd = 1; e.nwr = 0; e.lat = 1;
      end else begin
        for (int i = 0; i < nb; i++) ref_bytes[base + i] = wd[8 * i +: 8];
        for (int i = 0; i < 4; i++) e.wr_word |= 32'(ref_bytes[wbase + i]) << (8 * i);
        e.rdata = STORE_RSP_DATA ? e.wr_word : 32'h0;
        e.nrd   = (nb == 4) ? 0 : 1;
        e.nwr   = 1;
        e.lat   = (nb == 4) ? 1 : 2;
      end
    end
  endtask

  task automatic sample();
    exp_t e;
    if (!chk_en) begin
      prev_hs = 0; prev_cont = 0; rd_seen = 0; wr_seen = 0;
      return;
    end
    chk("rd_wr_exclusive", {30'h0, bus.mem_memRead, bus.mem_memWrite} & 32'h3, {30'h0, bus.mem_memRead & ~bus.mem_memWrite, bus.mem_memWrite & ~bus.mem_memRead});
    if (prev_hs) begin
      chk("after_rsp_valid", bus.rsp_valid, 0);
      chk("after_rsp_req_ready", bus.req_ready, 1);
    end
    if (exp_q.size() == 0) begin
      chk("idle_activity", {bus.mem_memRead, bus.mem_memWrite, bus.rsp_valid}, 0);
    end else begin
      e = exp_q[0];
      if (bus.mem_memRead) begin
        rd_seen++;
        chk("rd_addr", bus.mem_address, e.waddr);
      end
      if (bus.mem_memWrite) begin
        wr_seen++;
        last_wr = bus.mem_writeData;
        chk("wr_addr", bus.mem_address, e.waddr);
        chk("wr_data", bus.mem_writeData, e.wr_word);
      end
      if (bus.rsp_valid) begin
        if (!prev_cont) begin
          chk("latency", cyc - e.acc_cyc, e.lat);
          chk("read_cycles", rd_seen, e.nrd);
          chk("write_cycles", wr_seen, e.nwr);
        end
        chk("rsp_rdata", bus.rsp_rdata, e.rdata);
        chk("rsp_error", bus.rsp_error, e.err);
        chk("rsp_req_ready", bus.req_ready, 0);
        chk("rsp_mem_quiet", {bus.mem_memRead, bus.mem_memWrite}, 0);
        if (bus.rsp_ready) begin
          void'(exp_q.pop_front());
          rd_seen = 0;
          wr_seen = 0;
        end
      end
    end
    prev_hs   = bus.rsp_valid & bus.rsp_ready;
    prev_cont = bus.rsp_valid & ~bus.rsp_ready;
  endtask

  task automatic tick();
    @(negedge clock);
    sample();
    @(posedge clock);
    cyc++;
    #1;
  endtask

  task automatic do_req(input bit w, input logic [1:0] sz, input bit u,
                        input logic [31:0] a, input logic [31:0] wd, input int stall);
    int   n = 0;
    exp_t e;
    while (!bus.req_ready && n < 50) begin tick(); n++; end
    if (!bus.req_ready) begin fail_now("req_ready_wait"); return; end
    bus.req_write    = w;
    bus.req_size     = sz;
    bus.req_unsigned = u;
    bus.req_addr     = a;
    bus.req_wdata    = wd;
    bus.req_valid    = 1'b1;
    predict(w, sz, u, a, wd, e);
    e.acc_cyc = cyc + 1;
    exp_q.push_back(e);
    tick();
    bus.req_valid = 1'b0;
    n = 0;
    while (!bus.rsp_valid && n < 50) begin tick(); n++; end
    if (!bus.rsp_valid) begin fail_now("rsp_valid_wait"); exp_q.delete(); return; end
    repeat (stall) tick();
    got     = bus.rsp_rdata;
    got_err = bus.rsp_error;
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_bytes[i] = 8'h00;
    bus.req_valid = 0; bus.req_write = 0; bus.req_size = 0; bus.req_unsigned = 0;
    bus.req_addr = 0; bus.req_wdata = 0; bus.rsp_ready = 0;
    last_wr = 0; got = 0; got_err = 0;
    tick(); tick();
    chk("reset_req_ready", bus.req_ready, 1);
    chk("reset_outputs", {bus.rsp_valid, bus.rsp_error, bus.mem_memRead, bus.mem_memWrite}, 0);
    chk("reset_rdata", bus.rsp_rdata, 0);
    chk("reset_mem_address", bus.mem_address, 0);
    reset_n = 1'b1;
    tick();
    chk_en = 1'b1;

    do_req(1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 0);
    chk("sw_10_wdata", last_wr, 32'hDEADBEEF);
    chk("sw_10_err", got_err, 0);
    do_req(0, 2'd2, 0, 32'h10, 32'h0, 0);
    chk("lw_10", got, 32'hDEADBEEF);
    do_req(0, 2'd0, 0, 32'h13, 32'h0, 0);
    chk("lb_13", got, 32'hFFFFFFDE);
    do_req(0, 2'd0, 1, 32'h13, 32'h0, 0);
    chk("lbu_13", got, 32'h000000DE);
    do_req(0, 2'd1, 0, 32'h12, 32'h0, 0);
    chk("lh_12", got, 32'hFFFFDEAD);
    do_req(0, 2'd1, 1, 32'h10, 32'h0, 0);
    chk("lhu_10", got, 32'h0000BEEF);
    do_req(0, 2'd0, 0, 32'h10, 32'h0, 0);
    chk("lb_10", got, 32'hFFFFFFEF);

    do_req(1, 2'd0, 0, 32'h11, 32'h00000055, 0);
    chk("sb_11_wdata", last_wr, 32'hDEAD55EF);
    do_req(1, 2'd1, 0, 32'h12, 32'h00001234, 0);
    chk("sh_12_wdata", last_wr, 32'h123455EF);
    do_req(0, 2'd2, 0, 32'h10, 32'h0, 0);
    chk("lw_10_merged", got, 32'h123455EF);
    do_req(0, 2'd3, 0, 32'h10, 32'h0, 0);
    chk("lw_size3", got, 32'h123455EF);

    do_req(0, 2'd2, 0, 32'h10, 32'h0, 5);
    chk("lw_backpressure", got, 32'h123455EF);

    do_req(0, 2'd2, 0, 32'h12, 32'h0, 0);
`ifdef LSU_MISALIGN_CHECK_EN
    chk("lw_12_err", got_err, 1);
    chk("lw_12_rdata", got, 32'h0);
`else
    chk("lw_12_err", got_err, 0);
    chk("lw_12_rdata", got, 32'h123455EF);
`endif
    do_req(0, 2'd1, 1, 32'h13, 32'h0, 0);
`ifdef LSU_MISALIGN_CHECK_EN
    chk("lhu_13_err", got_err, 1);
    chk("lhu_13_rdata", got, 32'h0);
`else
    chk("lhu_13_err", got_err, 0);
    chk("lhu_13_rdata", got, 32'h00001234);
`endif

    // Abort a word store while it is in its write cycle.
    chk_en = 1'b0;
    tick();
    bus.req_write = 1; bus.req_size = 2'd2; bus.req_unsigned = 0;
    bus.req_addr = 32'h20; bus.req_wdata = 32'hA5A5A5A5; bus.req_valid = 1;
    tick();
    bus.req_valid = 0;
    chk("wr_before_reset", bus.mem_memWrite, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_memwrite", bus.mem_memWrite, 0);
    chk("async_rst_rsp_valid", bus.rsp_valid, 0);
    chk("async_rst_req_ready", bus.req_ready, 1);
    tick(); tick();
    reset_n = 1'b1;
    tick();
    chk("post_rst_req_ready", bus.req_ready, 1);
    chk_en = 1'b1;
    do_req(0, 2'd2, 0, 32'h10, 32'h0, 0);
    chk("lw_after_reset", got, 32'h123455EF);
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lsu_mem_master.md
Name: lsu_mem_master

Overview:
- Load/store unit that sits between the processor's MEM stage and the word-wide data memory.
- Accepts one byte, halfword or word load/store request at a time over a valid/ready handshake.
- Drives the memory's address, writeData, memWrite and memRead pins. It performs read-modify-write for sub-word stores and sign/zero extension for sub-word loads.
- Returns one response per request over a valid/ready handshake.

Parameters:
- ADDR_WIDTH, 32, width of req_addr and mem_address.
- STORE_RSP_DATA, 0, value placed on rsp_rdata for store responses: 0 = zero; 1 = merged word written.

Ports:
- clock  in  1  system clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request this cycle
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = treated as word
- req_unsigned  in  1  loads only: zero-extend instead of sign-extend
- req_addr  in  ADDR_WIDTH  byte address
- req_wdata  in  32  store data, right-justified
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer takes the response
- rsp_rdata  out  32  load result, extended
- rsp_error  out  1  misaligned request (see Optional Feature)
- mem_address  out  ADDR_WIDTH  to memory address; low two bits always 0
- mem_writeData  out  32  to memory writeData
- mem_memWrite  out  1  to memory memWrite
- mem_memRead  out  1  to memory memRead
- mem_readData  in  32  from memory; combinational while mem_memRead = 1

Behaviour:
- Reset state: all outputs 0 except req_ready = 1; FSM in IDLE.
- Reset is asynchronous and aborts any operation mid-flight:
  - mem_memWrite deasserts immediately.
  - A pending write is not guaranteed to land.
  - No response is produced for the aborted request.
- Byte lanes are little-endian:
  - Byte k occupies bits [8k+7:8k], selected by addr[1:0].
  - A halfword occupies the lower half when addr[1] = 0 and the upper half when addr[1] = 1.
- FSM states: IDLE, RD, RMW_RD, WR, RSP.
- IDLE:
  - req_ready = 1.
  - A request is accepted when req_valid & req_ready; all request fields are latched.
  - Next state: load goes to RD; word store goes to WR; byte/half store goes to RMW_RD; misaligned request (feature on) goes to RSP.
- RD:
  - Drive mem_memRead = 1 and mem_address = {addr[ADDR_WIDTH-1:2], 2'b00}.
  - At the clock edge, capture the extracted and extended lane into rsp_rdata, then go to RSP.
- RMW_RD:
  - Same memory read as RD.
  - At the clock edge, merge the req_wdata lane into the captured word, then go to WR.
- WR:
  - Drive mem_memWrite = 1 for exactly one cycle, with mem_writeData equal to the full or merged word.
  - The memory writes on that clock edge; next state is RSP.
- RSP:
  - rsp_valid = 1.
  - rsp_rdata and rsp_error are held stable until rsp_valid & rsp_ready, then go to IDLE.
  - req_ready = 0 throughout.
- mem_memRead and mem_memWrite are never asserted together and are 0 in IDLE and RSP.
- Latency from the acceptance edge to rsp_valid: load 1 cycle; word store 1 cycle; sub-word store 2 cycles.
- Throughput: one request per 3 cycles minimum, since there is no request/response overlap.
- Stores produce rsp_error = 0 and rsp_rdata per STORE_RSP_DATA.
- req_* inputs are ignored outside IDLE.

Optional Feature:
- Macro LSU_MISALIGN_CHECK_EN.
- Defined:
  - A half with addr[0] = 1, or a word/size-3 access with addr[1:0] != 0, is misaligned.
  - A misaligned request skips all memory access and goes IDLE to RSP with rsp_error = 1 and rsp_rdata = 0.
- Undefined:
  - Offending low address bits are ignored (half uses addr[1], word uses none).
  - rsp_error is tied to 0.

Decomposition:
- Package lsu_pkg holds:
  - lsu_size_t enum (SZ_BYTE, SZ_HALF, SZ_WORD).
  - lsu_state_t enum (the five FSM states).
  - Localparam WORD_BYTES = 4.
- One sub-module, lsu_lane_align, purely combinational:
  - extract(word, addr[1:0], size, unsigned) producing the load result.
  - merge(word, wdata, addr[1:0], size) producing the store word.
- The top level holds the FSM, request latches and handshakes.

Test Plan:
- Word store and reload: sw addr 0x10 data 0xDEADBEEF gives one mem_memWrite cycle with mem_address 0x10 and data 0xDEADBEEF, then rsp_valid with error 0. A following lw 0x10 returns 0xDEADBEEF, with rsp_valid one cycle after acceptance.
- Sub-word loads on that word:
  - lb 0x13 returns 0xFFFFFFDE.
  - lbu 0x13 returns 0x000000DE.
  - lh 0x12 returns 0xFFFFDEAD.
  - lhu 0x10 returns 0x0000BEEF.
  - lb 0x10 returns 0xFFFFFFEF.
- Read-modify-write:
  - sb 0x11 data 0x00000055 gives one memRead cycle, then one memWrite cycle with data 0xDEAD55EF.
  - sh 0x12 data 0x00001234 then writes 0x123455EF.
  - A final lw 0x10 returns 0x123455EF.
- Backpressure: during a load response, rsp_ready is held 0 for 5 cycles. rsp_valid and rsp_rdata must stay constant, req_ready must stay 0 and there is no memory activity. Raising rsp_ready gives IDLE on the next cycle.
- Misalignment:
  - lw 0x12 with LSU_MISALIGN_CHECK_EN gives no memRead/memWrite, rsp_error = 1 and rsp_rdata = 0.
  - The same request without the macro reads word 0x10 and returns 0x123455EF.
- Reset mid-store: reset_n is pulled low while in WR. mem_memWrite and rsp_valid must go 0 asynchronously. After release, req_ready = 1 and a new lw completes normally.
